// File: rtl/vga_pkg.sv
// Shared VGA timing definitions: default SVGA 800x600@60 constants, derived
// totals and sync windows, and the registered flag bundle used by the generator.
package vga_pkg;

    function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int sync_start(input int active, input int fp);
        return active + fp;
    endfunction

    function automatic int sync_end(input int active, input int fp, input int sync);
        return active + fp + sync - 1;
    endfunction

    // True when 'last' is representable as an unsigned value of 'width' bits.
    function automatic bit fits_width(input int last, input int width);
        if (width >= 31) return 1'b1;
        return (last >> width) == 0;
    endfunction

    localparam int VGA_H_ACTIVE   = 800;
    localparam int VGA_H_FP       = 40;
    localparam int VGA_H_SYNC     = 128;
    localparam int VGA_H_BP       = 88;
    localparam int VGA_V_ACTIVE   = 600;
    localparam int VGA_V_FP       = 1;
    localparam int VGA_V_SYNC     = 4;
    localparam int VGA_V_BP       = 23;
    localparam int VGA_H_SYNC_POL = 1;
    localparam int VGA_V_SYNC_POL = 1;
    localparam int VGA_CW         = 11;

    localparam int VGA_H_TOTAL      = axis_total(VGA_H_ACTIVE, VGA_H_FP, VGA_H_SYNC, VGA_H_BP);
    localparam int VGA_V_TOTAL      = axis_total(VGA_V_ACTIVE, VGA_V_FP, VGA_V_SYNC, VGA_V_BP);
    localparam int VGA_H_SYNC_START = sync_start(VGA_H_ACTIVE, VGA_H_FP);
    localparam int VGA_H_SYNC_END   = sync_end(VGA_H_ACTIVE, VGA_H_FP, VGA_H_SYNC);
    localparam int VGA_V_SYNC_START = sync_start(VGA_V_ACTIVE, VGA_V_FP);
    localparam int VGA_V_SYNC_END   = sync_end(VGA_V_ACTIVE, VGA_V_FP, VGA_V_SYNC);

    typedef struct packed {
        logic hsync;
        logic vsync;
        logic hblnk;
        logic vblnk;
        logic de;
        logic line_start;
        logic frame_start;
    } vga_flags_t;

endpackage

// File: rtl/vga_axis_ctr.sv
// Generic wrapping position counter for one raster axis; exposes the value it
// will take on the next edge so the parent can decode flags in the same edge.
module vga_axis_ctr #(
    parameter int TOTAL = 1056,
    parameter int CW    = 11
) (
    input  logic          pclk,
    input  logic          rst_n,
    input  logic          inc,
    output logic [CW-1:0] count_nxt,
    output logic [CW-1:0] count,
    output logic          wrap_nxt
);

    localparam logic [CW-1:0] LAST = CW'(TOTAL - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    assign wrap_nxt = inc && (count == LAST);

    always_comb begin
        // NOTE: default assigned first so no path leaves count_nxt unassigned (no latch).
        count_nxt = count;
        if (wrap_nxt) begin
            count_nxt = '0;
        end else if (inc) begin
            count_nxt = count + ONE;
        end
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            count <= count_nxt;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: counts, sync, blanking, data-enable
// and line/frame strobes, all registered from the next-state counts in one edge.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE   = VGA_H_ACTIVE,
    parameter int H_FP       = VGA_H_FP,
    parameter int H_SYNC     = VGA_H_SYNC,
    parameter int H_BP       = VGA_H_BP,
    parameter int V_ACTIVE   = VGA_V_ACTIVE,
    parameter int V_FP       = VGA_V_FP,
    parameter int V_SYNC     = VGA_V_SYNC,
    parameter int V_BP       = VGA_V_BP,
    parameter int H_SYNC_POL = VGA_H_SYNC_POL,
    parameter int V_SYNC_POL = VGA_V_SYNC_POL,
    parameter int CW         = VGA_CW
) (
    input  logic          pclk,
    input  logic          rst_n,
    input  logic          en,
    output logic [CW-1:0] hcount,
    output logic [CW-1:0] vcount,
    output logic          hsync,
    output logic          vsync,
    output logic          hblnk,
    output logic          vblnk,
    output logic          de,
    output logic          line_start,
    output logic          frame_start
);

    localparam int H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam logic [CW-1:0] H_ACT_C = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT_C = CW'(V_ACTIVE);
    localparam logic [CW-1:0] H_SS_C  = CW'(sync_start(H_ACTIVE, H_FP));
    localparam logic [CW-1:0] H_SE_C  = CW'(sync_end(H_ACTIVE, H_FP, H_SYNC));
    localparam logic [CW-1:0] V_SS_C  = CW'(sync_start(V_ACTIVE, V_FP));
    localparam logic [CW-1:0] V_SE_C  = CW'(sync_end(V_ACTIVE, V_FP, V_SYNC));

    localparam logic HS_ON = (H_SYNC_POL != 0);
    localparam logic VS_ON = (V_SYNC_POL != 0);

    // Reset presents pixel (0,0): visible, outside both sync windows, no strobe.
    localparam vga_flags_t FLAGS_RST = '{
        hsync:       ~HS_ON,
        vsync:       ~VS_ON,
        hblnk:       1'b0,
        vblnk:       1'b0,
        de:          1'b1,
        line_start:  1'b0,
        frame_start: 1'b0
    };

    if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1) begin : g_bad_h_timing
        $fatal(1, "vga_timing_gen: every horizontal timing parameter must be >= 1");
    end
    if (V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_v_timing
        $fatal(1, "vga_timing_gen: every vertical timing parameter must be >= 1");
    end
    if (CW < 1 || !fits_width(H_TOTAL - 1, CW)) begin : g_bad_h_width
        $fatal(1, "vga_timing_gen: H_TOTAL-1 does not fit in CW bits");
    end
    if (CW < 1 || !fits_width(V_TOTAL - 1, CW)) begin : g_bad_v_width
        $fatal(1, "vga_timing_gen: V_TOTAL-1 does not fit in CW bits");
    end

    logic [CW-1:0] h_nxt;
    logic [CW-1:0] v_nxt;
    logic          h_wrap_nxt;
    logic          v_wrap_nxt;
    logic          v_inc;
    vga_flags_t    flags_d;
    vga_flags_t    flags_q;

    assign v_inc = en && h_wrap_nxt;

    vga_axis_ctr #(
        .TOTAL (H_TOTAL),
        .CW    (CW)
    ) u_h_ctr (
        .pclk      (pclk),
        .rst_n     (rst_n),
        .inc       (en),
        .count_nxt (h_nxt),
        .count     (hcount),
        .wrap_nxt  (h_wrap_nxt)
    );

    vga_axis_ctr #(
        .TOTAL (V_TOTAL),
        .CW    (CW)
    ) u_v_ctr (
        .pclk      (pclk),
        .rst_n     (rst_n),
        .inc       (v_inc),
        .count_nxt (v_nxt),
        .count     (vcount),
        .wrap_nxt  (v_wrap_nxt)
    );

    // Decoding the next-state counts keeps flags aligned with the counts they describe.
    always_comb begin
        flags_d             = FLAGS_RST;
        flags_d.hblnk       = (h_nxt >= H_ACT_C);
        flags_d.vblnk       = (v_nxt >= V_ACT_C);
        flags_d.hsync       = (h_nxt >= H_SS_C && h_nxt <= H_SE_C) ? HS_ON : ~HS_ON;
        flags_d.vsync       = (v_nxt >= V_SS_C && v_nxt <= V_SE_C) ? VS_ON : ~VS_ON;
        flags_d.de          = !flags_d.hblnk && !flags_d.vblnk;
        flags_d.line_start  = h_wrap_nxt;
        flags_d.frame_start = h_wrap_nxt && v_wrap_nxt;
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= FLAGS_RST;
        end else begin
            flags_q <= flags_d;
        end
    end

    assign hsync       = flags_q.hsync;
    assign vsync       = flags_q.vsync;
    assign hblnk       = flags_q.hblnk;
    assign vblnk       = flags_q.vblnk;
    assign de          = flags_q.de;
    assign line_start  = flags_q.line_start;
    assign frame_start = flags_q.frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default SVGA instance and a small 14x8 instance,
// checked each cycle against an arithmetic raster model plus literal expectations.
module tb_vga_timing_gen;

    localparam int AHA = 800, AHF = 40, AHS = 128, AHB = 88;
    localparam int AVA = 600, AVF = 1, AVS = 4, AVB = 23;
    localparam int BHA = 8, BHF = 2, BHS = 3, BHB = 1;
    localparam int BVA = 4, BVF = 1, BVS = 2, BVB = 1;

    typedef struct packed {
        logic [31:0] h;
        logic [31:0] v;
        logic hs, vs, hb, vb, de, ls, fs;
    } exp_t;

    logic pclk = 1'b0;
    logic rst_n = 1'b1;
    logic en_a = 1'b0;
    logic en_b = 1'b0;

    logic [10:0] hcount_a, vcount_a;
    logic hsync_a, vsync_a, hblnk_a, vblnk_a, de_a, ls_a, fs_a;
    logic [3:0] hcount_b, vcount_b;
    logic hsync_b, vsync_b, hblnk_b, vblnk_b, de_b, ls_b, fs_b;

    int n_checks = 0;
    int n_err = 0;

    longint pos_a = 0, pos_b = 0;
    bit last_a = 1'b0, last_b = 1'b0;

    always #5 pclk = ~pclk;

    vga_timing_gen u_dut_a (
        .pclk(pclk), .rst_n(rst_n), .en(en_a),
        .hcount(hcount_a), .vcount(vcount_a), .hsync(hsync_a), .vsync(vsync_a),
        .hblnk(hblnk_a), .vblnk(vblnk_a), .de(de_a),
        .line_start(ls_a), .frame_start(fs_a)
    );

    vga_timing_gen #(
        .H_ACTIVE(BHA), .H_FP(BHF), .H_SYNC(BHS), .H_BP(BHB),
        .V_ACTIVE(BVA), .V_FP(BVF), .V_SYNC(BVS), .V_BP(BVB),
        .H_SYNC_POL(0), .V_SYNC_POL(1), .CW(4)
    ) u_dut_b (
        .pclk(pclk), .rst_n(rst_n), .en(en_b),
        .hcount(hcount_b), .vcount(vcount_b), .hsync(hsync_b), .vsync(vsync_b),
        .hblnk(hblnk_b), .vblnk(vblnk_b), .de(de_b),
        .line_start(ls_b), .frame_start(fs_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Raster position follows from the number of enabled edges since reset.
    function automatic exp_t model(input longint pos, input bit last_en,
                                   input int ha, input int hf, input int hs, input int hb,
                                   input int va, input int vf, input int vs, input int vb,
                                   input bit hpol, input bit vpol);
        exp_t e;
        longint ht = ha + hf + hs + hb;
        longint vt = va + vf + vs + vb;
        longint h = pos % ht;
        longint v = (pos / ht) % vt;
        e.h  = 32'(h);
        e.v  = 32'(v);
        e.hb = (h >= ha);
        e.vb = (v >= va);
        e.hs = (h >= ha + hf && h < ha + hf + hs) ? hpol : !hpol;
        e.vs = (v >= va + vf && v < va + vf + vs) ? vpol : !vpol;
        e.de = !e.hb && !e.vb;
        e.ls = last_en && (h == 0) && (pos > 0);
        e.fs = e.ls && (v == 0);
        return e;
    endfunction

    task automatic cmp(input string tag, input logic [31:0] h, input logic [31:0] v,
                       input logic hs, input logic vs, input logic hb, input logic vb,
                       input logic de, input logic ls, input logic fs, input exp_t e);
        check({tag, "_hcount"}, h, e.h);
        check({tag, "_vcount"}, v, e.v);
        check({tag, "_hsync"}, 32'(hs), 32'(e.hs));
        check({tag, "_vsync"}, 32'(vs), 32'(e.vs));
        check({tag, "_hblnk"}, 32'(hb), 32'(e.hb));
        check({tag, "_vblnk"}, 32'(vb), 32'(e.vb));
        check({tag, "_de"}, 32'(de), 32'(e.de));
        check({tag, "_line_start"}, 32'(ls), 32'(e.ls));
        check({tag, "_frame_start"}, 32'(fs), 32'(e.fs));
    endtask

    always @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            pos_a  <= 0;
            pos_b  <= 0;
            last_a <= 1'b0;
            last_b <= 1'b0;
        end else begin
            last_a <= en_a;
            last_b <= en_b;
            if (en_a) pos_a <= pos_a + 1;
            if (en_b) pos_b <= pos_b + 1;
        end
    end

    always @(negedge pclk) begin
        cmp("a", 32'(hcount_a), 32'(vcount_a), hsync_a, vsync_a, hblnk_a, vblnk_a, de_a, ls_a, fs_a,
            model(pos_a, last_a, AHA, AHF, AHS, AHB, AVA, AVF, AVS, AVB, 1'b1, 1'b1));
        cmp("b", 32'(hcount_b), 32'(vcount_b), hsync_b, vsync_b, hblnk_b, vblnk_b, de_b, ls_b, fs_b,
            model(pos_b, last_b, BHA, BHF, BHS, BHB, BVA, BVF, BVS, BVB, 1'b0, 1'b1));
    end

    task automatic check_b_reset(input string tag);
        check({tag, "_hcount"}, 32'(hcount_b), 0);
        check({tag, "_vcount"}, 32'(vcount_b), 0);
        check({tag, "_hsync"}, 32'(hsync_b), 1);
        check({tag, "_vsync"}, 32'(vsync_b), 0);
        check({tag, "_hblnk"}, 32'(hblnk_b), 0);
        check({tag, "_vblnk"}, 32'(vblnk_b), 0);
        check({tag, "_de"}, 32'(de_b), 1);
        check({tag, "_line_start"}, 32'(ls_b), 0);
        check({tag, "_frame_start"}, 32'(fs_b), 0);
    endtask

    initial begin
        int pulse_at [2];
        int n_pulses;
        int run_err;
        bit prev_ls;
        bit pat [4];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};

        // Asynchronous reset before any clock edge.
        #1 rst_n = 1'b0;
        #1;
        check("rst_a_hcount", 32'(hcount_a), 0);
        check("rst_a_vcount", 32'(vcount_a), 0);
        check("rst_a_hsync", 32'(hsync_a), 0);
        check("rst_a_vsync", 32'(vsync_a), 0);
        check("rst_a_de", 32'(de_a), 1);
        check("rst_a_line_start", 32'(ls_a), 0);
        check_b_reset("rst_b");
        @(posedge pclk); #1;
        rst_n = 1'b1;
        en_a  = 1'b1;

        // Default timing, continuous enable: line structure of the first lines.
        for (int k = 1; k <= 1060; k++) begin
            @(posedge pclk); #1;
            case (k)
                1: begin
                    check("a1_hcount", 32'(hcount_a), 1);
                    check("a1_vcount", 32'(vcount_a), 0);
                    check("a1_line_start", 32'(ls_a), 0);
                    check("a1_frame_start", 32'(fs_a), 0);
                end
                799: begin check("a799_hblnk", 32'(hblnk_a), 0); check("a799_de", 32'(de_a), 1); end
                800: begin check("a800_hblnk", 32'(hblnk_a), 1); check("a800_de", 32'(de_a), 0); end
                839: check("a839_hsync", 32'(hsync_a), 0);
                840: check("a840_hsync", 32'(hsync_a), 1);
                967: check("a967_hsync", 32'(hsync_a), 1);
                968: check("a968_hsync", 32'(hsync_a), 0);
                1055: check("a1055_hcount", 32'(hcount_a), 1055);
                1056: begin
                    check("a1056_hcount", 32'(hcount_a), 0);
                    check("a1056_vcount", 32'(vcount_a), 1);
                    check("a1056_line_start", 32'(ls_a), 1);
                    check("a1056_frame_start", 32'(fs_a), 0);
                    check("a1056_hblnk", 32'(hblnk_a), 0);
                end
                1057: check("a1057_line_start", 32'(ls_a), 0);
                default: ;
            endcase
        end

        // Enable pattern 1,0,0,1: line period doubles, strobes stay one pclk wide.
        n_pulses = 0;
        run_err  = 0;
        prev_ls  = 1'b0;
        for (int c = 0; c < 4400; c++) begin
            @(posedge pclk); #1;
            if (ls_a) begin
                if (n_pulses < 2) pulse_at[n_pulses] = c;
                n_pulses++;
                if (prev_ls) run_err++;
            end
            prev_ls = ls_a;
            en_a = pat[c % 4];
        end
        en_a = 1'b0;
        check("a_gated_pulses", 32'(n_pulses), 2);
        check("a_gated_line_period", 32'(pulse_at[1] - pulse_at[0]), 2112);
        check("a_gated_strobe_width", 32'(run_err), 0);

        // Small 14x8 timing with active-low hsync.
        en_b = 1'b1;
        for (int k = 1; k <= 159; k++) begin
            @(posedge pclk); #1;
            case (k)
                1: begin check("b1_hcount", 32'(hcount_b), 1); check("b1_vcount", 32'(vcount_b), 0); end
                7: begin check("b7_hblnk", 32'(hblnk_b), 0); check("b7_de", 32'(de_b), 1); end
                8: begin check("b8_hblnk", 32'(hblnk_b), 1); check("b8_de", 32'(de_b), 0); end
                9: check("b9_hsync", 32'(hsync_b), 1);
                10: check("b10_hsync", 32'(hsync_b), 0);
                12: check("b12_hsync", 32'(hsync_b), 0);
                13: check("b13_hsync", 32'(hsync_b), 1);
                14: begin
                    check("b14_hcount", 32'(hcount_b), 0);
                    check("b14_vcount", 32'(vcount_b), 1);
                    check("b14_line_start", 32'(ls_b), 1);
                    check("b14_frame_start", 32'(fs_b), 0);
                end
                69: begin check("b69_vsync", 32'(vsync_b), 0); check("b69_vblnk", 32'(vblnk_b), 1); end
                70: begin check("b70_vsync", 32'(vsync_b), 1); check("b70_vcount", 32'(vcount_b), 5); end
                97: check("b97_vsync", 32'(vsync_b), 1);
                98: check("b98_vsync", 32'(vsync_b), 0);
                111: begin check("b111_hcount", 32'(hcount_b), 13); check("b111_vcount", 32'(vcount_b), 7); end
                112: begin
                    check("b112_hcount", 32'(hcount_b), 0);
                    check("b112_vcount", 32'(vcount_b), 0);
                    check("b112_line_start", 32'(ls_b), 1);
                    check("b112_frame_start", 32'(fs_b), 1);
                end
                113: begin check("b113_line_start", 32'(ls_b), 0); check("b113_frame_start", 32'(fs_b), 0); end
                159: begin check("b159_hcount", 32'(hcount_b), 5); check("b159_vcount", 32'(vcount_b), 3); end
                default: ;
            endcase
        end

        // Mid-frame reset between edges, then restart from (0,0) with no strobe.
        #2 rst_n = 1'b0;
        #1;
        check_b_reset("midrst_b");
        check("midrst_a_hcount", 32'(hcount_a), 0);
        @(posedge pclk); #1;
        rst_n = 1'b1;
        for (int k = 1; k <= 113; k++) begin
            @(posedge pclk); #1;
            case (k)
                1: begin
                    check("r1_hcount", 32'(hcount_b), 1);
                    check("r1_vcount", 32'(vcount_b), 0);
                    check("r1_line_start", 32'(ls_b), 0);
                    check("r1_frame_start", 32'(fs_b), 0);
                end
                14: begin check("r14_line_start", 32'(ls_b), 1); check("r14_frame_start", 32'(fs_b), 0); end
                112: check("r112_frame_start", 32'(fs_b), 1);
                113: check("r113_frame_start", 32'(fs_b), 0);
                default: ;
            endcase
        end
        en_b = 1'b0;
        @(posedge pclk); #1;

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised VGA/SVGA raster timing generator; next generation of the fixed 800x600 timing block.
- Drives hcount/vcount, sync, blanking and data-enable to the draw pipeline and the VGA output stage.
- Adds:
  - per-axis porch/sync/polarity parameters;
  - pixel-enable input, so pclk may be faster than the pixel rate;
  - line_start/frame_start strobes;
  - guaranteed same-cycle alignment of counts and all flags.

Parameters:
- H_ACTIVE, 800, visible pixels per line
- H_FP, 40, horizontal front porch (pixels)
- H_SYNC, 128, hsync width (pixels)
- H_BP, 88, horizontal back porch (pixels)
- V_ACTIVE, 600, visible lines per frame
- V_FP, 1, vertical front porch (lines)
- V_SYNC, 4, vsync width (lines)
- V_BP, 23, vertical back porch (lines)
- H_SYNC_POL, 1, hsync active level (1 = active-high)
- V_SYNC_POL, 1, vsync active level
- CW, 11, width of hcount/vcount

Ports:
- pclk  in  1  pixel-domain clock, rising edge
- rst_n  in  1  asynchronous reset, active-low
- en  in  1  pixel enable; counters and flags advance only when high
- hcount  out  CW  horizontal position, 0..H_TOTAL-1
- vcount  out  CW  vertical position, 0..V_TOTAL-1
- hsync  out  1  horizontal sync, level per H_SYNC_POL
- vsync  out  1  vertical sync, level per V_SYNC_POL
- hblnk  out  1  horizontal blanking
- vblnk  out  1  vertical blanking
- de  out  1  data enable (visible pixel)
- line_start  out  1  one-pclk strobe on entry to hcount=0
- frame_start  out  1  one-pclk strobe on entry to (0,0)

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 1056). V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 628).
- Reset (rst_n=0, asynchronous, takes effect without a clock edge):
  - hcount=0, vcount=0, hblnk=0, vblnk=0, de=1;
  - hsync=!H_SYNC_POL, vsync=!V_SYNC_POL;
  - line_start=0, frame_start=0.
- Reset deassertion is used synchronously. The first enabled edge after reset moves to (1,0).
- All outputs are registered. Next-state counts are computed combinationally. Every flag is decoded from the next-state counts and registered in the same edge, so every output always describes the currently presented (hcount,vcount). Zero skew between counts and flags.
- Enabled edge (en=1):
  - hcount increments; at H_TOTAL-1 it wraps to 0.
  - vcount increments only on an hcount wrap; at V_TOTAL-1 with the hcount wrap, both go to 0.
- en=0: counts, sync, blank and de hold their values.
- hblnk=1 iff hcount in [H_ACTIVE, H_TOTAL-1].
- vblnk=1 iff vcount in [V_ACTIVE, V_TOTAL-1].
- hsync active iff hcount in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1].
- vsync active iff vcount in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1]. vsync therefore changes only together with hcount=0.
- de = !hblnk && !vblnk, registered.
- line_start=1 for exactly one pclk after an enabled edge that wraps hcount to 0; it is cleared on the next pclk regardless of en.
- frame_start: same rule for a wrap to (0,0); it coincides with line_start.
- Reset state (0,0) does not raise either strobe.
- Elaboration-time checks, each causing a fatal error:
  - every timing parameter must be >=1;
  - H_TOTAL-1 and V_TOTAL-1 must fit in CW bits.
- Reset mid-frame: outputs return to reset values immediately; the next frame starts from (0,0) with no strobe.

Decomposition:
- Shared package vga_pkg holds:
  - default SVGA 800x600@60 timing constants (values above);
  - derived totals, sync-start and sync-end helper constants.
  The top level and the draw blocks both import it.
- One sub-module: vga_axis_ctr. It is a generic wrapping counter with inputs pclk, rst_n, inc and parameter TOTAL, and outputs count_nxt, count and wrap_nxt.
  - Instanced twice: horizontal instance with inc=en; vertical instance with inc=en && h wrap_nxt.
  - Flag decode lives in the top level.

Test Plan:
- Defaults, en=1, after reset:
  - hblnk rises at hcount=800 and falls at 0;
  - hsync high for hcount 840..967 (128 clocks);
  - period 1056 clocks;
  - de=0 exactly when hcount>=800 or vcount>=600.
- Defaults, full frame:
  - vsync high for vcount 601..604, rising together with hcount=0;
  - frame_start every 1056*628 = 663168 enabled clocks, each coinciding with (0,0) and line_start.
- Small config H=8/2/3/1, V=4/1/2/1, H_SYNC_POL=0:
  - hsync low exactly at hcount 10..12, high otherwise;
  - totals 14x8; wrap from (13,7) to (0,0).
- en toggling 1,0,0,1 repeatedly (divide-by-4 style):
  - counts advance only on en=1 edges;
  - line_start/frame_start high for exactly one pclk;
  - the frame period scales proportionally.
- Assert rst_n=0 mid-line at (500,300) between clock edges:
  - outputs return to reset values before the next edge;
  - after release, the sequence restarts at (1,0) with no frame_start until the next wrap.
- Parameter check: CW=10 with default timing (H_TOTAL-1=1055) must fail elaboration.
